// File: rtl/data_mem_responder_if.sv
// Core bus and host loader signals for data_mem_responder.
// slave is the memory side; master is the core/host driving it.
interface data_mem_responder_if;
  logic [31:0] RAM_IN_ADDRESS;
  logic [31:0] RAM_IN_DATA;
  logic        RAM_IN_WRITE;
  logic [31:0] RAM_OUT;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_done;
  logic        busy;
  logic        oor_err;

  modport slave (
    input  RAM_IN_ADDRESS, RAM_IN_DATA, RAM_IN_WRITE, ld_start, ld_valid, ld_byte,
    output RAM_OUT, ld_ready, ld_done, busy, oor_err
  );

  modport master (
    output RAM_IN_ADDRESS, RAM_IN_DATA, RAM_IN_WRITE, ld_start, ld_valid, ld_byte,
    input  RAM_OUT, ld_ready, ld_done, busy, oor_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed flop memory with zero-wait core access and a byte-serial
// host loader that fills every word before handing the memory back.
module data_mem_responder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state_reg;
  logic [AW-1:0] ptr_reg;
  logic [1:0]    bc_reg;
  logic [31:0]   asm_reg;
  logic          ld_done_reg;
  logic          oor_err_reg;
  logic [31:0]   mem_reg [DEPTH];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          core_we;
  logic          load_we;
  logic [31:0]   load_word;

  assign idx       = bus.RAM_IN_ADDRESS[AW-1:0];
  assign in_range  = (bus.RAM_IN_ADDRESS[31:AW] == '0);
  assign core_we   = (state_reg == IDLE) && bus.RAM_IN_WRITE && in_range;
  assign load_we   = (state_reg == LOAD) && bus.ld_valid && (bc_reg == 2'd3);
  // Top byte bypasses the assembly register so the word lands on the 4th edge.
  assign load_word = {bus.ld_byte, asm_reg[23:0]};

  // Loader and core writes are mutually exclusive by state.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (load_we && (ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= load_word;
        end else if (core_we && (idx == AW'(gi))) begin
          mem_reg[gi] <= bus.RAM_IN_DATA;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      bc_reg      <= '0;
      asm_reg     <= '0;
      ld_done_reg <= 1'b0;
      oor_err_reg <= 1'b0;
    end else begin
      ld_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!in_range) begin
            oor_err_reg <= 1'b1;
          end
          if (bus.ld_start) begin
            state_reg <= LOAD;
            ptr_reg   <= '0;
            bc_reg    <= '0;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            asm_reg[{bc_reg, 3'b000} +: 8] <= bus.ld_byte;
            bc_reg <= bc_reg + 2'd1;
            if (bc_reg == 2'd3) begin
              ptr_reg <= ptr_reg + 1'b1;
              if (ptr_reg == AW'(DEPTH - 1)) begin
                state_reg   <= IDLE;
                ld_done_reg <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.RAM_OUT = '0;
    if ((state_reg == IDLE) && in_range) begin
      bus.RAM_OUT = mem_reg[idx];
    end
  end

  assign bus.busy     = (state_reg == LOAD);
  assign bus.ld_ready = (state_reg == LOAD);
  assign bus.ld_done  = ld_done_reg;
  assign bus.oor_err  = oor_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array/byte-count model.
module tb_data_mem_responder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk;
  logic rst_n;
  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  int done_seen = 0;
  logic [31:0] last_rd;

  // Reference model: memory contents, load progress and flags.
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_bytes [4];
  logic        m_busy;
  logic        m_oor;
  logic        m_done;
  int          m_nb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 1'b0;
    m_oor  = 1'b0;
    m_done = 1'b0;
    m_nb   = 0;
  endtask

  task automatic step(input logic [31:0] addr, input logic [31:0] data, input logic we,
                      input logic start, input logic valid, input logic [7:0] b);
    logic [31:0] exp_rd;
    logic        next_done;
    @(negedge clk);
    bus.RAM_IN_ADDRESS = addr;
    bus.RAM_IN_DATA    = data;
    bus.RAM_IN_WRITE   = we;
    bus.ld_start       = start;
    bus.ld_valid       = valid;
    bus.ld_byte        = b;
    #1;
    exp_rd  = (m_busy || addr >= DEPTH) ? 32'h0 : m_mem[addr % DEPTH];
    last_rd = bus.RAM_OUT;
    if (bus.ld_done === 1'b1) done_seen++;
    chk("rdata",    bus.RAM_OUT, exp_rd);
    chk("busy",     {31'b0, bus.busy},     {31'b0, m_busy});
    chk("ld_ready", {31'b0, bus.ld_ready}, {31'b0, m_busy});
    chk("ld_done",  {31'b0, bus.ld_done},  {31'b0, m_done});
    chk("oor_err",  {31'b0, bus.oor_err},  {31'b0, m_oor});
    n_txn++;
    $display("txn %0d addr=%h wd=%h we=%b st=%b v=%b b=%h rd=%h busy=%b done=%b oor=%b",
             n_txn, addr, data, we, start, valid, b, bus.RAM_OUT, bus.busy, bus.ld_done, bus.oor_err);
    @(posedge clk);
    next_done = 1'b0;
    if (!m_busy) begin
      if (addr >= DEPTH) m_oor = 1'b1;
      else if (we) m_mem[addr] = data;
      if (start) begin
        m_busy = 1'b1;
        m_nb   = 0;
      end
    end else if (valid) begin
      m_bytes[m_nb % 4] = b;
      m_nb++;
      if (m_nb % 4 == 0)
        m_mem[m_nb / 4 - 1] = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      if (m_nb == 4 * DEPTH) begin
        m_busy    = 1'b0;
        m_nb      = 0;
        next_done = 1'b1;
      end
    end
    m_done = next_done;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.RAM_IN_ADDRESS = '0;
    bus.RAM_IN_WRITE   = 1'b0;
    bus.ld_start       = 1'b0;
    bus.ld_valid       = 1'b0;
    #1;
    model_reset();
    chk("rst_rdata", bus.RAM_OUT, 32'h0);
    chk("rst_busy",  {31'b0, bus.busy},     32'h0);
    chk("rst_ready", {31'b0, bus.ld_ready}, 32'h0);
    chk("rst_done",  {31'b0, bus.ld_done},  32'h0);
    chk("rst_oor",   {31'b0, bus.oor_err},  32'h0);
    $display("txn reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Streams bytes with random gaps; during gaps a blocked core write and a
  // redundant ld_start are presented.
  task automatic do_load(input bit seq_bytes, input int stop_after);
    int k = 0;
    int guard = 0;
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    while (m_busy && k < stop_after && guard < 2000) begin
      guard++;
      if ($urandom_range(0, 2) == 0) begin
        step(32'h0, 32'h1, 1'b1, 1'b1, 1'b0, 8'hAA);
      end else begin
        step(32'($urandom_range(0, 15)), 32'h1, 1'b1, 1'b0, 1'b1,
             seq_bytes ? k[7:0] : 8'($urandom));
        k++;
      end
    end
    chk("load_bound", {31'b0, guard >= 2000}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.RAM_IN_ADDRESS = '0;
    bus.RAM_IN_DATA    = '0;
    bus.RAM_IN_WRITE   = 1'b0;
    bus.ld_start       = 1'b0;
    bus.ld_valid       = 1'b0;
    bus.ld_byte        = '0;
    model_reset();
    do_reset();

    // Core write then read-back, neighbour stays zero.
    step(32'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 8'h00);
    step(32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rw_addr3", last_rd, 32'hDEADBEEF);
    step(32'd4, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rw_addr4", last_rd, 32'h0);

    // Read-during-write returns old data, then new.
    step(32'd5, 32'h55, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("rdw_old", last_rd, 32'h0);
    step(32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rdw_new", last_rd, 32'h55);

    // Out-of-range write: zero read, sticky flag, memory untouched.
    step(32'h10, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("oor_rdata", last_rd, 32'h0);
    for (int a = 0; a < DEPTH; a++) step(32'(a), 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("oor_sticky", {31'b0, bus.oor_err}, 32'h1);

    // Full sequential load with gaps.
    done_seen = 0;
    do_load(1'b1, 4 * DEPTH);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ld_word0", last_rd, 32'h03020100);
    step(32'd15, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ld_word15", last_rd, 32'h3F3E3D3C);
    chk("ld_done_cnt", 32'(done_seen), 32'd1);
    for (int a = 0; a < DEPTH; a++) step(32'(a), 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of a load, then a full random load.
    do_load(1'b0, 10);
    do_reset();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("abort_w0", last_rd, 32'h0);
    step(32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("abort_w1", last_rd, 32'h0);
    done_seen = 0;
    do_load(1'b0, 4 * DEPTH);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ld2_done_cnt", 32'(done_seen), 32'd1);
    for (int a = 0; a < DEPTH; a++) step(32'(a), 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Unconstrained random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15)),
           $urandom, 1'($urandom), ($urandom_range(0, 15) == 0),
           1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
